// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with a single
// registered output stage. Channel selection is either fixed (sel) or fair
// round-robin starting after the last granted channel.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   mode                0 = fixed select, 1 = round-robin
//   sel                 channel index used in fixed mode
//   in_valid/in_data    per-channel request, channel i at [i*WIDTH +: WIDTH]
//   in_ready            per-channel ready, one-hot or zero (combinational)
//   out_valid/out_data  registered output word
//   out_ch              source channel of out_data
//   out_ready           consumer ready
module rr_stream_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_accept;
  logic             w_grant;
  logic [SEL_W-1:0] w_g;
  logic [CHANNELS-1:0] w_rdy;
  int               w_best;
  int               w_dist;

  assign w_accept = !r_out_valid || out_ready;

  // Round-robin: each channel's distance from ptr+1 (mod CHANNELS) ranks it,
  // so ptr itself has the largest distance and is searched last.
  always_comb begin
    w_grant = 1'b0;
    w_g     = '0;
    w_best  = CHANNELS;
    w_dist  = 0;
    if (mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        w_dist = (i + CHANNELS - 1 - int'(r_ptr)) % CHANNELS;
        if (in_valid[i] && (w_dist < w_best)) begin
          w_best  = w_dist;
          w_grant = 1'b1;
          w_g     = SEL_W'(i);
        end
      end
    end else begin
      // Out-of-range sel matches no channel, so it produces no grant.
      for (int i = 0; i < CHANNELS; i++) begin
        if ((sel == SEL_W'(i)) && in_valid[i]) begin
          w_grant = 1'b1;
          w_g     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_rdy = '0;
    if (rst_n && w_accept && w_grant) w_rdy[w_g] = 1'b1;
  end

  assign in_ready = w_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SEL_W'(CHANNELS - 1);
    end else if (w_accept) begin
      if (w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_g*WIDTH +: WIDTH];
        r_out_ch    <= w_g;
        r_ptr       <= w_g;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst_n, mode, out_ready;
  logic [1:0]  sel;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;

  rr_stream_mux u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  // CHANNELS=3, WIDTH=8 instance
  logic        rst3_n, mode3, out_ready3;
  logic [1:0]  sel3;
  logic [2:0]  in_valid3, in_ready3;
  logic [23:0] in_data3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;

  rr_stream_mux #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [3:0]  e_data;
    logic [1:0]  e_ch;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (default instance)
  bit       m_valid;
  bit [3:0] m_data;
  bit [1:0] m_ch;
  int       m_ptr;

  // Build the spec's search order explicitly, then take the first valid one.
  function automatic void mdl_grant(input bit md, input bit [1:0] s, input bit [3:0] v,
                                    input int ptr, output bit ok, output int g);
    int order[$];
    ok = 0; g = 0;
    if (!md) begin
      if (v[s]) begin ok = 1; g = s; end
    end else begin
      for (int k = 1; k <= 4; k++) order.push_back((ptr + k) % 4);
      foreach (order[j]) if (!ok && v[order[j]]) begin ok = 1; g = order[j]; end
    end
  endfunction

  initial begin
    bit ok; int g; bit acc; bit [3:0] erdy;

    rst_n = 0; mode = 0; sel = 0; in_valid = 4'hF; in_data = 16'h8421; out_ready = 1;
    rst3_n = 0; mode3 = 0; sel3 = 0; in_valid3 = 3'b111; in_data3 = 24'hC3B2A1; out_ready3 = 1;

    // reset state
    #1; chk("rst_in_ready", in_ready, 0);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_in_ready_held", in_ready, 0);
    rst_n = 1;

    // fixed sweep, sparse round-robin wrap, backpressure, no-grant
    tbl.push_back('{0, 0, 4'hF, 16'h8421, 1, 4'b0001, 1, 4'h1, 0});
    tbl.push_back('{0, 1, 4'hF, 16'h8421, 1, 4'b0010, 1, 4'h2, 1});
    tbl.push_back('{0, 2, 4'hF, 16'h8421, 1, 4'b0100, 1, 4'h4, 2});
    tbl.push_back('{0, 3, 4'hF, 16'h8421, 1, 4'b1000, 1, 4'h8, 3});
    tbl.push_back('{1, 0, 4'hA, 16'h8421, 1, 4'b0010, 1, 4'h2, 1});
    tbl.push_back('{1, 0, 4'hA, 16'h8421, 1, 4'b1000, 1, 4'h8, 3});
    tbl.push_back('{1, 0, 4'hA, 16'h8421, 1, 4'b0010, 1, 4'h2, 1});
    tbl.push_back('{1, 0, 4'hA, 16'h8421, 1, 4'b1000, 1, 4'h8, 3});
    tbl.push_back('{1, 0, 4'h4, 16'h8421, 1, 4'b0100, 1, 4'h4, 2});
    tbl.push_back('{1, 0, 4'hF, 16'h8421, 0, 4'b0000, 1, 4'h4, 2});
    tbl.push_back('{1, 0, 4'hF, 16'h8421, 0, 4'b0000, 1, 4'h4, 2});
    tbl.push_back('{1, 0, 4'hF, 16'h8421, 0, 4'b0000, 1, 4'h4, 2});
    tbl.push_back('{1, 0, 4'hF, 16'h8421, 1, 4'b1000, 1, 4'h8, 3});
    tbl.push_back('{0, 1, 4'h5, 16'h8421, 1, 4'b0000, 0, 4'h8, 3});
    tbl.push_back('{1, 0, 4'hF, 16'h8421, 0, 4'b0001, 1, 4'h1, 0});

    foreach (tbl[i]) begin
      mode = tbl[i].mode; sel = tbl[i].sel; in_valid = tbl[i].vld;
      in_data = tbl[i].data; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      tick();
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_out_ch", i), out_ch, tbl[i].e_ch);
    end

    // round-robin rotation from reset, data = channel index
    rst_n = 0; tick(); rst_n = 1;
    mode = 1; in_valid = 4'hF; in_data = 16'h3210; out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("rot%0d_out_valid", c), out_valid, 1);
      chk($sformatf("rot%0d_out_ch", c), out_ch, c % 4);
      chk($sformatf("rot%0d_out_data", c), out_data, c % 4);
    end

    // reset mid-stream
    rst_n = 0; #1;
    chk("midrst_in_ready", in_ready, 0);
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ch", out_ch, 0);
    rst_n = 1; tick();
    chk("midrst_first_ch", out_ch, 0);
    chk("midrst_first_valid", out_valid, 1);

    // out-of-range select on 3-channel instance
    tick(); rst3_n = 1;
    tick();
    chk("ch3_sel0_ch", out_ch3, 0);
    chk("ch3_sel0_data", out_data3, 8'hA1);
    sel3 = 3; #1;
    chk("ch3_sel3_in_ready", in_ready3, 0);
    tick();
    chk("ch3_sel3_out_valid", out_valid3, 0);
    sel3 = 2; #1;
    chk("ch3_sel2_in_ready", in_ready3, 3'b100);
    tick();
    chk("ch3_sel2_out_ch", out_ch3, 2);
    chk("ch3_sel2_out_data", out_data3, 8'hC3);
    chk("ch3_sel2_out_valid", out_valid3, 1);

    // randomized run against the reference model
    rst_n = 0; tick();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 3;
    for (int it = 0; it < 1500; it++) begin
      rst_n     = ($urandom_range(99) >= 3);
      mode      = $urandom_range(1);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc = !m_valid || out_ready;
      mdl_grant(mode, sel, in_valid, m_ptr, ok, g);
      erdy = (rst_n && acc && ok) ? (4'b1 << g) : 4'b0;
      chk($sformatf("rnd%0d_in_ready", it), in_ready, erdy);
      if (!rst_n) begin
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 3;
      end else if (acc) begin
        if (ok) begin
          m_valid = 1; m_data = in_data[g*4 +: 4]; m_ch = 2'(g); m_ptr = g;
        end else m_valid = 0;
      end
      tick();
      chk($sformatf("rnd%0d_out_valid", it), out_valid, m_valid);
      chk($sformatf("rnd%0d_out_data", it), out_data, m_data);
      chk($sformatf("rnd%0d_out_ch", it), out_ch, m_ch);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
